// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN stack controller: token kinds, FSM states,
// and the depth-counter width helper.
package rpn_pkg;

  localparam logic [2:0] K_NUM     = 3'd0;
  localparam logic [2:0] K_ADD     = 3'd1;
  localparam logic [2:0] K_SUB     = 3'd2;
  localparam logic [2:0] K_AND     = 3'd3;
  localparam logic [2:0] K_OR      = 3'd4;
  localparam logic [2:0] K_XOR     = 3'd5;
  localparam logic [2:0] K_EMIT    = 3'd6;
  localparam logic [2:0] K_ILLEGAL = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PUSH,
    S_POP_B,
    S_POP_A,
    S_CALC,
    S_POP_R,
    S_CAP_R,
    S_OUT,
    S_ERR,
    S_FLUSH
  } state_t;

  // Bits needed to count 0..depth inclusive.
  function automatic int unsigned depth_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational binary operator for RPN tokens; a is the deeper operand.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       kind,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (kind)
      K_ADD:   result = a + b;
      K_SUB:   result = a - b;
      K_AND:   result = a & b;
      K_OR:    result = a | b;
      K_XOR:   result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN token controller driving an external push/pop Stack: sequences operand
// pops, ALU ops, result pushes and EMIT reads, with depth tracking and errors.
module rpn_stack_ctrl
  import rpn_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned DW    = depth_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_tok_valid,
  output logic             io_tok_ready,
  input  logic [2:0]       io_tok_kind,
  input  logic [WIDTH-1:0] io_tok_value,
  output logic             io_res_valid,
  input  logic             io_res_ready,
  output logic [WIDTH-1:0] io_res_bits,
  output logic             io_error,
  input  logic             io_clear,
  output logic [DW-1:0]    io_depth,
  output logic             io_stk_en,
  output logic             io_stk_push,
  output logic             io_stk_pop,
  output logic [WIDTH-1:0] io_stk_dataIn,
  input  logic [WIDTH-1:0] io_stk_dataOut
);

  state_t           state;
  logic [2:0]       kind;
  logic [WIDTH-1:0] wr;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] alu_result;
  logic [DW-1:0]    depth_after;

  assign io_stk_dataIn = wr;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .kind  (kind),
    .a     (io_stk_dataOut),
    .b     (b),
    .result(alu_result)
  );

  // Occupancy once the Stack command issued this cycle has taken effect.
  always_comb begin
    depth_after = io_depth;
    if (io_stk_en && io_stk_push)
      depth_after = io_depth + DW'(1);
    else if (io_stk_en && io_stk_pop)
      depth_after = io_depth - DW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      kind         <= K_NUM;
      wr           <= '0;
      b            <= '0;
      io_depth     <= '0;
      io_error     <= 1'b0;
      io_res_valid <= 1'b0;
      io_res_bits  <= '0;
      io_tok_ready <= 1'b1;
      io_stk_en    <= 1'b0;
      io_stk_push  <= 1'b0;
      io_stk_pop   <= 1'b0;
    end else begin
      io_stk_en   <= 1'b0;
      io_stk_push <= 1'b0;
      io_stk_pop  <= 1'b0;
      if (io_clear && state != S_FLUSH) begin
        // Let any in-flight Stack command land so the count stays exact.
        io_depth     <= depth_after;
        io_error     <= 1'b0;
        io_res_valid <= 1'b0;
        io_tok_ready <= 1'b0;
        state        <= S_FLUSH;
        if (depth_after != '0) begin
          io_stk_en  <= 1'b1;
          io_stk_pop <= 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (io_tok_valid) begin
              kind <= io_tok_kind;
              case (io_tok_kind)
                K_NUM: begin
                  if (io_depth == DW'(DEPTH)) begin
                    io_error <= 1'b1;
                    state    <= S_ERR;
                  end else begin
                    wr           <= io_tok_value;
                    io_tok_ready <= 1'b0;
                    io_stk_en    <= 1'b1;
                    io_stk_push  <= 1'b1;
                    state        <= S_PUSH;
                  end
                end
                K_ADD, K_SUB, K_AND, K_OR, K_XOR: begin
                  if (io_depth < DW'(2)) begin
                    io_error <= 1'b1;
                    state    <= S_ERR;
                  end else begin
                    io_tok_ready <= 1'b0;
                    io_stk_en    <= 1'b1;
                    io_stk_pop   <= 1'b1;
                    state        <= S_POP_B;
                  end
                end
                K_EMIT: begin
                  if (io_depth == '0) begin
                    io_error <= 1'b1;
                    state    <= S_ERR;
                  end else begin
                    io_tok_ready <= 1'b0;
                    io_stk_en    <= 1'b1;
                    io_stk_pop   <= 1'b1;
                    state        <= S_POP_R;
                  end
                end
                default: begin
                  io_error <= 1'b1;
                  state    <= S_ERR;
                end
              endcase
            end
          end
          S_POP_B: begin
            io_depth   <= depth_after;
            io_stk_en  <= 1'b1;
            io_stk_pop <= 1'b1;
            state      <= S_POP_A;
          end
          S_POP_A: begin
            io_depth <= depth_after;
            b        <= io_stk_dataOut;
            state    <= S_CALC;
          end
          S_CALC: begin
            wr          <= alu_result;
            io_stk_en   <= 1'b1;
            io_stk_push <= 1'b1;
            state       <= S_PUSH;
          end
          S_PUSH: begin
            io_depth     <= depth_after;
            io_tok_ready <= 1'b1;
            state        <= S_IDLE;
          end
          S_POP_R: begin
            io_depth <= depth_after;
            state    <= S_CAP_R;
          end
          S_CAP_R: begin
            io_res_bits  <= io_stk_dataOut;
            io_res_valid <= 1'b1;
            state        <= S_OUT;
          end
          S_OUT: begin
            if (io_res_ready) begin
              io_res_valid <= 1'b0;
              io_tok_ready <= 1'b1;
              state        <= S_IDLE;
            end
          end
          S_ERR: begin
            io_tok_ready <= 1'b1;
          end
          S_FLUSH: begin
            io_depth <= depth_after;
            if (depth_after == '0) begin
              io_tok_ready <= 1'b1;
              state        <= S_IDLE;
            end else begin
              io_stk_en  <= 1'b1;
              io_stk_pop <= 1'b1;
            end
          end
          default: begin
            io_tok_ready <= 1'b1;
            state        <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
